// File: rtl/pc_fetch_if.sv
// pc_fetch_if -- bundle between the fetch stage, its instruction LUT and decode.
//   master : the fetch stage. It drives prog_ctr, instr, instr_pc, instr_valid,
//            done and instr_count. It receives mach_code, br_taken, br_target
//            and decode_ready.
//   slave  : the environment (LUT, branch unit, decode), with the opposite directions.
//   D      : program counter width, equal to log2 of the LUT depth.
interface pc_fetch_if #(
  parameter int D = 12
);
  logic [D-1:0] prog_ctr;
  logic [8:0]   mach_code;
  logic         br_taken;
  logic [D-1:0] br_target;
  logic [8:0]   instr;
  logic [D-1:0] instr_pc;
  logic         instr_valid;
  logic         decode_ready;
  logic         done;
  logic [15:0]  instr_count;

  modport master (
    output prog_ctr, instr, instr_pc, instr_valid, done, instr_count,
    input  mach_code, br_taken, br_target, decode_ready
  );

  modport slave (
    input  prog_ctr, instr, instr_pc, instr_valid, done, instr_count,
    output mach_code, br_taken, br_target, decode_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch -- single-entry instruction fetch stage with HALT detection.
// Ports:
//   clk      : the only clock; all state changes on its rising edge.
//   reset_n  : synchronous, active-low reset.
//   bus      : pc_fetch_if.master.
//              prog_ctr goes to the LUT, and mach_code comes back combinationally.
//              br_taken and br_target carry a redirect.
//              instr, instr_pc and instr_valid are presented to decode, which answers with decode_ready.
//              done is raised once the HALT word is accepted.
//              instr_count is the saturating count of accepted instructions.
// Parameters:
//   D         : program counter width.
//   HALT_CODE : machine word that stops fetch once decode has accepted it.
module pc_fetch #(
  parameter int         D         = 12,
  parameter logic [8:0] HALT_CODE = 9'h1FF
) (
  input logic        clk,
  input logic        reset_n,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t       state_q;
  logic [D-1:0] pc_q;
  logic [D-1:0] instr_pc_q;
  logic [8:0]   instr_q;
  logic         valid_q;
  logic         done_q;
  logic [15:0]  count_q;

  logic         accept;
  logic         free;
  logic [15:0]  count_d;
  logic [D-1:0] pc_d;

  assign accept = valid_q & bus.decode_ready;
  assign free   = ~valid_q | accept;

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  // Incrementing the address wraps naturally modulo 2^D.
  assign pc_d = pc_q + D'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_q       <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      // The counter follows decode's handshake and ignores the FSM state.
      // An acceptance in the same cycle as a flush still counts.
      count_q <= count_d;
      case (state_q)
        RUN: begin
          if (bus.br_taken) begin
            pc_q    <= bus.br_target;
            valid_q <= 1'b0;
          end else if (free) begin
            instr_q    <= bus.mach_code;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_d;
            if (bus.mach_code == HALT_CODE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // A redirect beats the HALT: the HALT was on a wrong path.
          if (bus.br_taken) begin
            pc_q    <= bus.br_target;
            valid_q <= 1'b0;
            state_q <= RUN;
          end else if (accept) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= HALTED;
          end
        end
        HALTED: begin
          // Only reset leaves this state. Redirects are ignored here.
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch.
// Inputs are changed and outputs sampled on the falling edge.
// The LUT holds the non-HALT word {addr[7:0]}+1 at every address.
// HALT is planted at address 5 only for the halt-related scenarios.
module tb_pc_fetch;
  localparam int D = 12;
  localparam logic [8:0] HALT = 9'h1FF;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [8:0] lut [0:4095];

  pc_fetch_if #(.D(D)) bus ();

  pc_fetch #(.D(D), .HALT_CODE(HALT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.mach_code = lut[bus.prog_ctr];

  function automatic logic [8:0] word_at(input int a);
    logic [8:0] w;
    w = {1'b0, 8'(a)} + 9'd1;
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.decode_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.br_taken = 1'b1;
    bus.br_target = 12'h123;
    bus.decode_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.prog_ctr !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", bus.prog_ctr); end
    n_vec++; if (bus.instr !== 9'h000) begin n_err++; $display("FAIL reset_instr got %h want 000", bus.instr); end
    n_vec++; if (bus.instr_pc !== 12'h000) begin n_err++; $display("FAIL reset_instr_pc got %h want 000", bus.instr_pc); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.instr_count !== 16'h0000) begin n_err++; $display("FAIL reset_count got %h want 0000", bus.instr_count); end
    bus.br_taken = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_straight();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (bus.instr_pc !== 12'(k)) begin n_err++; $display("FAIL straight_pc%0d got %h want %h", k, bus.instr_pc, 12'(k)); end
      n_vec++; if (bus.prog_ctr !== 12'(k + 1)) begin n_err++; $display("FAIL straight_prog%0d got %h want %h", k, bus.prog_ctr, 12'(k + 1)); end
      n_vec++; if (bus.instr !== word_at(k)) begin n_err++; $display("FAIL straight_instr%0d got %h want %h", k, bus.instr, word_at(k)); end
      n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL straight_valid%0d got %b want 1", k, bus.instr_valid); end
      n_vec++; if (bus.instr_count !== 16'(k)) begin n_err++; $display("FAIL straight_count%0d got %h want %h", k, bus.instr_count, 16'(k)); end
    end
    tick();
    n_vec++; if (bus.instr_count !== 16'd4) begin n_err++; $display("FAIL straight_count_final got %h want 0004", bus.instr_count); end
    $display("test_straight done");
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    n_vec++; if (bus.instr_pc !== 12'h002) begin n_err++; $display("FAIL stall_setup got %h want 002", bus.instr_pc); end
    bus.decode_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (bus.instr_pc !== 12'h002) begin n_err++; $display("FAIL stall_pc%0d got %h want 002", k, bus.instr_pc); end
      n_vec++; if (bus.prog_ctr !== 12'h003) begin n_err++; $display("FAIL stall_prog%0d got %h want 003", k, bus.prog_ctr); end
      n_vec++; if (bus.instr !== 9'h003) begin n_err++; $display("FAIL stall_instr%0d got %h want 003", k, bus.instr); end
      n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d got %b want 1", k, bus.instr_valid); end
      n_vec++; if (bus.instr_count !== 16'd2) begin n_err++; $display("FAIL stall_count%0d got %h want 0002", k, bus.instr_count); end
    end
    bus.decode_ready = 1'b1;
    tick();
    n_vec++; if (bus.instr_pc !== 12'h003) begin n_err++; $display("FAIL stall_resume_pc got %h want 003", bus.instr_pc); end
    n_vec++; if (bus.prog_ctr !== 12'h004) begin n_err++; $display("FAIL stall_resume_prog got %h want 004", bus.prog_ctr); end
    n_vec++; if (bus.instr_count !== 16'd3) begin n_err++; $display("FAIL stall_resume_count got %h want 0003", bus.instr_count); end
    $display("test_stall done");
  endtask

  // Runs straight after test_stall: instr_pc=3 is live, and prog_ctr=4.
  task automatic test_branch_stall();
    bus.decode_ready = 1'b0;
    tick();
    bus.br_taken = 1'b1;
    bus.br_target = 12'h040;
    tick();
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL brstall_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.prog_ctr !== 12'h040) begin n_err++; $display("FAIL brstall_prog got %h want 040", bus.prog_ctr); end
    n_vec++; if (bus.instr_count !== 16'd3) begin n_err++; $display("FAIL brstall_count got %h want 0003", bus.instr_count); end
    bus.br_taken = 1'b0;
    bus.decode_ready = 1'b1;
    tick();
    n_vec++; if (bus.instr_pc !== 12'h040) begin n_err++; $display("FAIL brstall_pc got %h want 040", bus.instr_pc); end
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL brstall_valid2 got %b want 1", bus.instr_valid); end
    n_vec++; if (bus.instr !== 9'h041) begin n_err++; $display("FAIL brstall_instr got %h want 041", bus.instr); end
    n_vec++; if (bus.prog_ctr !== 12'h041) begin n_err++; $display("FAIL brstall_prog2 got %h want 041", bus.prog_ctr); end
    $display("test_branch_stall done");
  endtask

  task automatic test_halt();
    lut[5] = HALT;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    n_vec++; if (bus.instr !== HALT) begin n_err++; $display("FAIL halt_loaded got %h want %h", bus.instr, HALT); end
    n_vec++; if (bus.prog_ctr !== 12'h006) begin n_err++; $display("FAIL halt_prog_drain got %h want 006", bus.prog_ctr); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL halt_done_early got %b want 0", bus.done); end
    tick();
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL halt_done got %b want 1", bus.done); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.prog_ctr !== 12'h006) begin n_err++; $display("FAIL halt_prog got %h want 006", bus.prog_ctr); end
    n_vec++; if (bus.instr_count !== 16'd6) begin n_err++; $display("FAIL halt_count got %h want 0006", bus.instr_count); end
    bus.br_taken = 1'b1;
    bus.br_target = 12'h100;
    tick();
    tick();
    bus.br_taken = 1'b0;
    tick();
    n_vec++; if (bus.prog_ctr !== 12'h006) begin n_err++; $display("FAIL halt_br_prog got %h want 006", bus.prog_ctr); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL halt_br_done got %b want 1", bus.done); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_br_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.instr_pc !== 12'h005) begin n_err++; $display("FAIL halt_br_pc got %h want 005", bus.instr_pc); end
    n_vec++; if (bus.instr !== HALT) begin n_err++; $display("FAIL halt_br_instr got %h want %h", bus.instr, HALT); end
    $display("test_halt done");
  endtask

  task automatic test_drain_branch();
    lut[5] = HALT;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    bus.br_taken = 1'b1;
    bus.br_target = 12'h010;
    tick();
    bus.br_taken = 1'b0;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL drainbr_done got %b want 0", bus.done); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL drainbr_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.prog_ctr !== 12'h010) begin n_err++; $display("FAIL drainbr_prog got %h want 010", bus.prog_ctr); end
    n_vec++; if (bus.instr_count !== 16'd6) begin n_err++; $display("FAIL drainbr_count got %h want 0006", bus.instr_count); end
    tick();
    n_vec++; if (bus.instr_pc !== 12'h010) begin n_err++; $display("FAIL drainbr_pc got %h want 010", bus.instr_pc); end
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL drainbr_valid2 got %b want 1", bus.instr_valid); end
    $display("test_drain_branch done");
  endtask

  task automatic test_reset_drain();
    lut[5] = HALT;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    bus.decode_ready = 1'b0;
    tick();
    n_vec++; if (bus.prog_ctr !== 12'h006) begin n_err++; $display("FAIL rstdrain_hold_prog got %h want 006", bus.prog_ctr); end
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rstdrain_hold_valid got %b want 1", bus.instr_valid); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++; if (bus.prog_ctr !== 12'h000) begin n_err++; $display("FAIL rstdrain_prog got %h want 000", bus.prog_ctr); end
    n_vec++; if (bus.instr !== 9'h000) begin n_err++; $display("FAIL rstdrain_instr got %h want 000", bus.instr); end
    n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rstdrain_valid got %b want 0", bus.instr_valid); end
    n_vec++; if (bus.instr_count !== 16'd0) begin n_err++; $display("FAIL rstdrain_count got %h want 0000", bus.instr_count); end
    bus.decode_ready = 1'b1;
    tick();
    n_vec++; if (bus.instr_pc !== 12'h000) begin n_err++; $display("FAIL rstdrain_restart_pc got %h want 000", bus.instr_pc); end
    n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rstdrain_restart_valid got %b want 1", bus.instr_valid); end
    n_vec++; if (bus.prog_ctr !== 12'h001) begin n_err++; $display("FAIL rstdrain_restart_prog got %h want 001", bus.prog_ctr); end
    lut[5] = word_at(5);
    $display("test_reset_drain done");
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    bus.br_taken = 1'b1;
    bus.br_target = 12'hFFF;
    tick();
    bus.br_taken = 1'b0;
    n_vec++; if (bus.prog_ctr !== 12'hFFF) begin n_err++; $display("FAIL wrap_prog got %h want fff", bus.prog_ctr); end
    tick();
    n_vec++; if (bus.instr_pc !== 12'hFFF) begin n_err++; $display("FAIL wrap_pc got %h want fff", bus.instr_pc); end
    n_vec++; if (bus.instr !== 9'h100) begin n_err++; $display("FAIL wrap_instr got %h want 100", bus.instr); end
    n_vec++; if (bus.prog_ctr !== 12'h000) begin n_err++; $display("FAIL wrap_prog0 got %h want 000", bus.prog_ctr); end
    tick();
    n_vec++; if (bus.instr_pc !== 12'h000) begin n_err++; $display("FAIL wrap_pc0 got %h want 000", bus.instr_pc); end
    n_vec++; if (bus.prog_ctr !== 12'h001) begin n_err++; $display("FAIL wrap_prog1 got %h want 001", bus.prog_ctr); end
    $display("test_wrap done");
  endtask

  // After edge N following reset, N-1 instructions have been accepted.
  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 65535; k++) tick();
    n_vec++; if (bus.instr_count !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe got %h want fffe", bus.instr_count); end
    tick();
    n_vec++; if (bus.instr_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got %h want ffff", bus.instr_count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (bus.instr_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold%0d got %h want ffff", k, bus.instr_count); end
    end
    $display("test_saturation done");
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) lut[a] = word_at(a);
    reset_n = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.decode_ready = 1'b0;
    tick();
    test_reset();
    test_straight();
    test_stall();
    test_branch_stall();
    test_halt();
    test_drain_branch();
    test_reset_drain();
    test_wrap();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
